// File: rtl/placar_basquete_n.sv
// Basketball scoreboard core: N_TIMES saturating team scores plus a 24/14 s shot clock with buzzer.
// Optional feature: define PLACAR_AUTO_SHOT24_EN so that accepted add events reload the long shot clock.
module placar_basquete_n #(
   parameter int N_TIMES      = 2,
   parameter int LARG         = 7,
   parameter int PLACAR_MAX   = 99,
   parameter int TICK_DIV     = 50_000_000,
   parameter int SHOT_LONGO   = 24,
   parameter int SHOT_CURTO   = 14,
   parameter int BUZZER_TICKS = 2,
   localparam int SEL_W       = (N_TIMES > 1) ? $clog2(N_TIMES) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [2:0]                btn_pontos,
   input  logic [SEL_W-1:0]          sel_time,
   input  logic                      subtrair,
   input  logic                      shot24,
   input  logic                      shot14,
   input  logic                      pausa,
   output logic [N_TIMES*LARG-1:0]   placar,
   output logic [4:0]                cronometro,
   output logic                      buzzer,
   output logic                      erro
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BUZZER_TICKS > 1) ? $clog2(BUZZER_TICKS) : 1;
   localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0]    BUZ_LAST  = BW'(BUZZER_TICKS - 1);
   localparam logic [LARG:0]    MAX_EXT   = (LARG+1)'(PLACAR_MAX);
   localparam logic [SEL_W:0]   N_SEL     = (SEL_W+1)'(N_TIMES);
   localparam logic [4:0]       LONGO     = 5'(SHOT_LONGO);
   localparam logic [4:0]       CURTO     = 5'(SHOT_CURTO);

   typedef enum logic [1:0] {PARADO = 2'd0, CONTANDO = 2'd1, ESTOURO = 2'd2} estado_t;

   logic [LARG-1:0]  score_r [N_TIMES];
   logic [2:0]       btn_q_r;
   logic             s24_q_r, s14_q_r;
   logic             erro_r;
   estado_t          state_r, state_n;
   logic [4:0]       crono_r, crono_n;
   logic             buzzer_r, buzzer_n;
   logic [BW-1:0]    bcnt_r, bcnt_n;
   logic [TW-1:0]    tcnt_r;

   logic [2:0]       btn_ev_s;
   logic [LARG:0]    val_s, sum_s;
   logic             single_s, multi_s, sel_ok_s;
   logic [SEL_W-1:0] sel_idx_s;
   logic [LARG-1:0]  cur_s, new_s;
   logic             wr_s, err_s, add_ok_s, auto_s;
   logic             reload_s, reload24_s, run_s, tick_s;
   logic [4:0]       reload_val_s;

   for (genvar k = 0; k < N_TIMES; k++) begin : g_placar
      assign placar[k*LARG +: LARG] = score_r[k];
   end
   assign cronometro = crono_r;
   assign buzzer     = buzzer_r;
   assign erro       = erro_r;

   // Score event decode: single-bit rising edge gives the value, sum is one bit wider than the score.
   always_comb begin
      btn_ev_s  = btn_pontos & ~btn_q_r;
      val_s     = '0;
      single_s  = 1'b0;
      multi_s   = 1'b0;
      case (btn_ev_s)
         3'b000:  single_s = 1'b0;
         3'b001:  begin single_s = 1'b1; val_s = (LARG+1)'(1); end
         3'b010:  begin single_s = 1'b1; val_s = (LARG+1)'(2); end
         3'b100:  begin single_s = 1'b1; val_s = (LARG+1)'(3); end
         default: multi_s = 1'b1;
      endcase
      sel_ok_s  = ({1'b0, sel_time} < N_SEL);
      sel_idx_s = sel_ok_s ? sel_time : '0;
      cur_s     = score_r[sel_idx_s];
      sum_s     = {1'b0, cur_s} + val_s;
      new_s     = cur_s;
      wr_s      = 1'b0;
      err_s     = 1'b0;
      add_ok_s  = 1'b0;
      if (multi_s) begin
         err_s = 1'b1;
      end else if (single_s) begin
         if (!sel_ok_s) begin
            err_s = 1'b1;
         end else if (!subtrair) begin
            wr_s     = 1'b1;
            add_ok_s = 1'b1;
            if (sum_s <= MAX_EXT) begin
               new_s = sum_s[LARG-1:0];
            end else begin
               new_s = MAX_EXT[LARG-1:0];
               err_s = 1'b1;
            end
         end else begin
            if (val_s <= {1'b0, cur_s}) begin
               wr_s  = 1'b1;
               new_s = cur_s - val_s[LARG-1:0];
            end else begin
               err_s = 1'b1;
            end
         end
      end else begin
         err_s = 1'b0;
      end
   end

`ifdef PLACAR_AUTO_SHOT24_EN
   assign auto_s = add_ok_s;
`else
   assign auto_s = 1'b0;
`endif

   assign reload24_s   = (shot24 & ~s24_q_r) | auto_s;
   assign reload_s     = reload24_s | (shot14 & ~s14_q_r);
   assign reload_val_s = reload24_s ? LONGO : CURTO;
   assign run_s        = ((state_r == CONTANDO) && !pausa) || (state_r == ESTOURO);
   assign tick_s       = run_s && (tcnt_r == TICK_LAST);

   // Score channels, edge-detect copies and the error pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < N_TIMES; k++) score_r[k] <= '0;
         btn_q_r <= 3'b000;
         s24_q_r <= 1'b0;
         s14_q_r <= 1'b0;
         erro_r  <= 1'b0;
      end else begin
         btn_q_r <= btn_pontos;
         s24_q_r <= shot24;
         s14_q_r <= shot14;
         erro_r  <= err_s;
         if (wr_s) score_r[sel_idx_s] <= new_s;
      end
   end

   // Tick divider; keeps running through the buzzer window regardless of pausa.
   always_ff @(posedge clock) begin
      if (reset || reload_s) begin
         tcnt_r <= '0;
      end else if (run_s) begin
         tcnt_r <= (tcnt_r == TICK_LAST) ? '0 : tcnt_r + TW'(1);
      end else begin
         tcnt_r <= tcnt_r;
      end
   end

   // Shot-clock state, seconds, buzzer and buzzer tick count registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= PARADO;
         crono_r  <= LONGO;
         buzzer_r <= 1'b0;
         bcnt_r   <= '0;
      end else begin
         state_r  <= state_n;
         crono_r  <= crono_n;
         buzzer_r <= buzzer_n;
         bcnt_r   <= bcnt_n;
      end
   end

   // Shot-clock next state: reload wins over ticks in every state.
   always_comb begin
      state_n  = state_r;
      crono_n  = crono_r;
      buzzer_n = buzzer_r;
      bcnt_n   = bcnt_r;
      if (reload_s) begin
         state_n  = CONTANDO;
         crono_n  = reload_val_s;
         buzzer_n = 1'b0;
         bcnt_n   = '0;
      end else begin
         case (state_r)
            PARADO: buzzer_n = 1'b0;
            CONTANDO: begin
               if (tick_s) begin
                  if (crono_r <= 5'd1) begin
                     state_n  = ESTOURO;
                     crono_n  = 5'd0;
                     buzzer_n = 1'b1;
                     bcnt_n   = '0;
                  end else begin
                     crono_n = crono_r - 5'd1;
                  end
               end else begin
                  crono_n = crono_r;
               end
            end
            ESTOURO: begin
               crono_n = 5'd0;
               if (tick_s) begin
                  if (bcnt_r == BUZ_LAST) begin
                     state_n  = PARADO;
                     buzzer_n = 1'b0;
                     bcnt_n   = '0;
                  end else begin
                     bcnt_n = bcnt_r + BW'(1);
                  end
               end else begin
                  bcnt_n = bcnt_r;
               end
            end
            default: begin
               state_n  = PARADO;
               buzzer_n = 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_placar_basquete_n.sv
// Directed bench for placar_basquete_n with three teams and a 4-cycle tick.
module tb_placar_basquete_n;
   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  btn_pontos;
   logic [1:0]  sel_time;
   logic        subtrair, shot24, shot14, pausa;
   logic [20:0] placar;
   logic [4:0]  cronometro;
   logic        buzzer, erro;
   logic        e_last;
   int          checks = 0;
   int          failures = 0;

   placar_basquete_n #(.N_TIMES(3), .TICK_DIV(4)) dut (
      .clock(clock), .reset(reset), .btn_pontos(btn_pontos), .sel_time(sel_time),
      .subtrair(subtrair), .shot24(shot24), .shot14(shot14), .pausa(pausa),
      .placar(placar), .cronometro(cronometro), .buzzer(buzzer), .erro(erro)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ch(input int k);
      return 32'(placar[k*7 +: 7]);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [2:0] b, input logic [1:0] s, input logic sub);
      btn_pontos = b; sel_time = s; subtrair = sub;
      step();
      e_last = erro;
      btn_pontos = 3'b000;
      step();
   endtask

   initial begin
      reset = 1'b1; btn_pontos = 3'b000; sel_time = 2'd0; subtrair = 1'b0;
      shot24 = 1'b0; shot14 = 1'b0; pausa = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("rst_placar", 32'(placar), 32'd0);
      chk("rst_crono", 32'(cronometro), 32'd24);
      chk("rst_buzzer", 32'(buzzer), 32'd0);
      chk("rst_erro", 32'(erro), 32'd0);

      for (int i = 0; i < 3; i++) begin
         press(3'b100, 2'd1, 1'b0);
         chk("erro_3pt", 32'(e_last), 32'd0);
      end
      chk("ch1_nine", ch(1), 32'd9);
      chk("ch0_zero", ch(0), 32'd0);

      for (int i = 0; i < 32; i++) press(3'b100, 2'd0, 1'b0);
      press(3'b010, 2'd0, 1'b0);
      chk("ch0_98", ch(0), 32'd98);
      press(3'b100, 2'd0, 1'b0);
      chk("clamp_erro", 32'(e_last), 32'd1);
      chk("clamp_val", ch(0), 32'd99);
      chk("erro_one_cycle", 32'(erro), 32'd0);
      chk("ch1_hold", ch(1), 32'd9);

      for (int i = 0; i < 32; i++) press(3'b100, 2'd0, 1'b1);
      press(3'b010, 2'd0, 1'b1);
      chk("ch0_one", ch(0), 32'd1);
      press(3'b010, 2'd0, 1'b1);
      chk("sub_under_val", ch(0), 32'd1);
      chk("sub_under_erro", 32'(e_last), 32'd1);

      btn_pontos = 3'b001; sel_time = 2'd0; subtrair = 1'b0;
      step(); step(); step();
      btn_pontos = 3'b000;
      step();
      chk("hold_once", ch(0), 32'd2);

      btn_pontos = 3'b011;
      step();
      chk("multi_erro", 32'(erro), 32'd1);
      btn_pontos = 3'b000;
      step();
      chk("multi_ch0", ch(0), 32'd2);
      chk("multi_ch1", ch(1), 32'd9);

      press(3'b001, 2'd3, 1'b0);
      chk("sel3_erro", 32'(e_last), 32'd1);
      chk("sel3_ch0", ch(0), 32'd2);
      chk("sel3_ch1", ch(1), 32'd9);
      chk("sel3_ch2", ch(2), 32'd0);

      press(3'b100, 2'd0, 1'b1);
      chk("sub3_erro", 32'(e_last), 32'd1);
      chk("sub3_ch0", ch(0), 32'd2);

      shot14 = 1'b1;
      step();
      chk("shot14_load", 32'(cronometro), 32'd14);
      shot14 = 1'b0;
      step(); step(); step();
      chk("before_tick", 32'(cronometro), 32'd14);
      step();
      chk("first_tick", 32'(cronometro), 32'd13);
      pausa = 1'b1;
      repeat (10) step();
      chk("paused", 32'(cronometro), 32'd13);
      pausa = 1'b0;
      repeat (51) step();
      chk("crono_one", 32'(cronometro), 32'd1);
      chk("buzzer_pre", 32'(buzzer), 32'd0);
      step();
      chk("crono_zero", 32'(cronometro), 32'd0);
      chk("buzzer_rise", 32'(buzzer), 32'd1);
      repeat (7) step();
      chk("buzzer_held", 32'(buzzer), 32'd1);
      step();
      chk("buzzer_fall", 32'(buzzer), 32'd0);
      repeat (5) step();
      chk("parado_zero", 32'(cronometro), 32'd0);

      shot14 = 1'b1;
      step();
      shot14 = 1'b0;
      repeat (56) step();
      chk("estouro_again", 32'(buzzer), 32'd1);
      step(); step();
      shot24 = 1'b1; shot14 = 1'b1;
      step();
      shot24 = 1'b0; shot14 = 1'b0;
      chk("both_reload", 32'(cronometro), 32'd24);
      chk("both_buzzer", 32'(buzzer), 32'd0);

      repeat (6) step();
      chk("count_23", 32'(cronometro), 32'd23);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_crono", 32'(cronometro), 32'd24);
      chk("midrst_score", ch(1), 32'd0);
      repeat (10) step();
      chk("midrst_parado", 32'(cronometro), 32'd24);

      shot14 = 1'b1;
      step();
      shot14 = 1'b0;
      repeat (36) step();
      chk("crono_five", 32'(cronometro), 32'd5);
      btn_pontos = 3'b010; sel_time = 2'd0; subtrair = 1'b0;
      step();
`ifdef PLACAR_AUTO_SHOT24_EN
      chk("auto_reload", 32'(cronometro), 32'd24);
`else
      chk("no_auto_reload", 32'(cronometro), 32'd5);
`endif
      chk("auto_score", ch(0), 32'd2);
      btn_pontos = 3'b000;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
